// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: ID/WB/flush request side and status returned by the register scoreboard
interface reg_scoreboard_if #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 32
);
  localparam int AW = $clog2(NUM_REGS);
  logic          id_valid;
  logic [AW-1:0] id_rs1_addr;
  logic          id_rs1_re;
  logic [AW-1:0] id_rs2_addr;
  logic          id_rs2_re;
  logic [AW-1:0] id_rd_addr;
  logic          id_rd_we;
  logic          id_long;
  logic          wb_done;
  logic [AW-1:0] wb_rd_addr;
  logic          flush;
  logic          stall;
  logic          busy;
  logic [5:0]    pending_cnt;
  logic [CNT_W-1:0] stall_cycles;
  logic          err_sticky;
  modport master (
    output id_valid, id_rs1_addr, id_rs1_re, id_rs2_addr, id_rs2_re,
           id_rd_addr, id_rd_we, id_long, wb_done, wb_rd_addr, flush,
    input  stall, busy, pending_cnt, stall_cycles, err_sticky
  );
  modport slave (
    input  id_valid, id_rs1_addr, id_rs1_re, id_rs2_addr, id_rs2_re,
           id_rd_addr, id_rd_we, id_long, wb_done, wb_rd_addr, flush,
    output stall, busy, pending_cnt, stall_cycles, err_sticky
  );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks GPRs awaiting long-latency writeback and stalls ID on RAW/WAW hazards
module reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 32
) (
  input logic            clk,
  input logic            rst,
  reg_scoreboard_if.slave sb
);
  logic [NUM_REGS-1:0] pending_q, pending_d, eff, wb_oh, rd_oh;
  logic [5:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;
  logic                err_q, err_d;
  logic                rs1_haz, rs2_haz, waw_haz, stall, issue, comp, comp_ok;
  assign wb_oh   = {{(NUM_REGS-1){1'b0}}, 1'b1} << sb.wb_rd_addr;
  assign rd_oh   = {{(NUM_REGS-1){1'b0}}, 1'b1} << sb.id_rd_addr;
  // A register completing this cycle is already readable: the register file is write-first.
  assign eff     = pending_q & ~(sb.wb_done ? wb_oh : '0);
  assign rs1_haz = sb.id_rs1_re & |sb.id_rs1_addr & eff[sb.id_rs1_addr];
  assign rs2_haz = sb.id_rs2_re & |sb.id_rs2_addr & eff[sb.id_rs2_addr];
  assign waw_haz = sb.id_rd_we & |sb.id_rd_addr & eff[sb.id_rd_addr];
  assign stall   = ~rst & sb.id_valid & ~sb.flush & (rs1_haz | rs2_haz | waw_haz);
  assign issue   = sb.id_valid & ~stall & ~sb.flush & sb.id_rd_we & sb.id_long & |sb.id_rd_addr;
  assign comp    = sb.wb_done & |sb.wb_rd_addr & ~sb.flush;
  assign comp_ok = comp & pending_q[sb.wb_rd_addr];
  // Next state: flush kills everything in flight; otherwise clear on completion then set on issue so a same-rd issue wins.
  always_comb begin
    pending_d      = sb.flush ? '0 : (pending_q & ~(comp_ok ? wb_oh : '0)) | (issue ? rd_oh : '0);
    pending_d[0]   = 1'b0;
    cnt_d          = sb.flush ? 6'd0 : cnt_q + 6'(issue) - 6'(comp_ok);
    err_d          = err_q | (comp & ~pending_q[sb.wb_rd_addr]);
    stall_cycles_d = (stall & ~&stall_cycles_q) ? stall_cycles_q + 1'b1 : stall_cycles_q;
  end
  // State registers with synchronous reset overriding every other update.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q      <= '0;
      cnt_q          <= '0;
      err_q          <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      pending_q      <= pending_d;
      cnt_q          <= cnt_d;
      err_q          <= err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end
  assign sb.stall        = stall;
  assign sb.busy         = |pending_q;
  assign sb.pending_cnt  = cnt_q;
  assign sb.stall_cycles = stall_cycles_q;
  assign sb.err_sticky   = err_q;
  a_cnt_matches_popcount: assert property (@(posedge clk) disable iff (rst) cnt_q == 6'($countones(pending_q)));
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed vectors with hand-computed expectations for reg_scoreboard
module tb_reg_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  reg_scoreboard_if #(.NUM_REGS(32), .CNT_W(4)) sb();
  reg_scoreboard #(.NUM_REGS(32), .CNT_W(4)) dut (.clk(clk), .rst(rst), .sb(sb));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic id(input logic v, input logic [4:0] r1, input logic e1, input logic [4:0] r2,
                    input logic e2, input logic [4:0] rd, input logic we, input logic lg);
    sb.id_valid = v; sb.id_rs1_addr = r1; sb.id_rs1_re = e1; sb.id_rs2_addr = r2;
    sb.id_rs2_re = e2; sb.id_rd_addr = rd; sb.id_rd_we = we; sb.id_long = lg;
  endtask
  task automatic wb(input logic d, input logic [4:0] a);
    sb.wb_done = d; sb.wb_rd_addr = a;
  endtask
  task automatic idle();
    id(0, 0, 0, 0, 0, 0, 0, 0); wb(0, 0); sb.flush = 1'b0;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  initial begin
    idle();
    tick(); tick();
    chk("rst_stall", sb.stall, 0);
    rst = 1'b0;
    #1;
    chk("rst_busy", sb.busy, 0);
    chk("rst_cnt", sb.pending_cnt, 0);
    chk("rst_sc", sb.stall_cycles, 0);
    chk("rst_err", sb.err_sticky, 0);
    id(1, 0, 0, 0, 0, 5, 1, 1); #1;
    chk("ld_x5_stall", sb.stall, 0);
    tick();
    chk("ld_x5_cnt", sb.pending_cnt, 1);
    chk("ld_x5_busy", sb.busy, 1);
    id(1, 5, 1, 1, 1, 6, 1, 0); #1;
    chk("raw_c2", sb.stall, 1);
    tick();
    chk("raw_c3", sb.stall, 1);
    tick();
    wb(1, 5); #1;
    chk("raw_release", sb.stall, 0);
    chk("raw_cnt_lag", sb.pending_cnt, 1);
    tick();
    idle(); #1;
    chk("raw_cnt", sb.pending_cnt, 0);
    chk("raw_busy", sb.busy, 0);
    chk("raw_sc", sb.stall_cycles, 2);
    id(1, 0, 0, 0, 0, 7, 1, 1); tick();
    chk("div_x7_cnt", sb.pending_cnt, 1);
    id(1, 1, 1, 2, 1, 7, 1, 1); #1;
    chk("waw_stall", sb.stall, 1);
    tick();
    wb(1, 7); #1;
    chk("waw_release", sb.stall, 0);
    tick();
    idle(); #1;
    chk("waw_cnt", sb.pending_cnt, 1);
    chk("waw_busy", sb.busy, 1);
    chk("waw_sc", sb.stall_cycles, 3);
    id(1, 1, 1, 0, 0, 8, 1, 0); #1;
    chk("waw_x7_still_pend", sb.stall, 0);
    id(1, 7, 1, 0, 0, 8, 1, 0); #1;
    chk("waw_x7_read", sb.stall, 1);
    idle(); wb(1, 7); tick();
    idle(); #1;
    chk("x7_done_cnt", sb.pending_cnt, 0);
    chk("x7_done_err", sb.err_sticky, 0);
    id(1, 0, 0, 0, 0, 0, 1, 1); #1;
    chk("x0_issue_stall", sb.stall, 0);
    tick();
    chk("x0_busy", sb.busy, 0);
    chk("x0_cnt", sb.pending_cnt, 0);
    id(1, 0, 1, 0, 1, 0, 1, 1); wb(1, 0); #1;
    chk("x0_read", sb.stall, 0);
    tick();
    idle(); #1;
    chk("x0_wb_err", sb.err_sticky, 0);
    id(1, 0, 0, 0, 0, 3, 1, 1); tick();
    id(1, 0, 0, 0, 0, 4, 1, 1); tick();
    id(1, 0, 0, 0, 0, 9, 1, 1); tick();
    idle(); #1;
    chk("fl_cnt3", sb.pending_cnt, 3);
    id(1, 3, 1, 0, 0, 10, 1, 1); wb(1, 3); sb.flush = 1'b1; #1;
    chk("fl_stall", sb.stall, 0);
    tick();
    idle(); #1;
    chk("fl_cnt", sb.pending_cnt, 0);
    chk("fl_busy", sb.busy, 0);
    chk("fl_err", sb.err_sticky, 0);
    chk("fl_sc", sb.stall_cycles, 3);
    id(1, 10, 1, 4, 1, 9, 1, 0); #1;
    chk("fl_x10_free", sb.stall, 0);
    id(1, 0, 0, 0, 0, 8, 1, 1); tick();
    idle(); wb(1, 12); tick();
    idle(); #1;
    chk("err_set", sb.err_sticky, 1);
    chk("err_cnt", sb.pending_cnt, 1);
    tick(); tick();
    chk("err_hold", sb.err_sticky, 1);
    id(1, 8, 0, 0, 0, 0, 0, 0); #1;
    chk("re_gate", sb.stall, 0);
    id(0, 8, 1, 0, 0, 0, 0, 0); #1;
    chk("valid_gate", sb.stall, 0);
    id(1, 0, 0, 8, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("sat_stall", sb.stall, 1);
      tick();
    end
    #1;
    chk("sat_sc", sb.stall_cycles, 15);
    rst = 1'b1; #1;
    chk("rst_forces_stall", sb.stall, 0);
    tick();
    rst = 1'b0; idle(); #1;
    chk("rst2_cnt", sb.pending_cnt, 0);
    chk("rst2_err", sb.err_sticky, 0);
    chk("rst2_sc", sb.stall_cycles, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Issue-side register scoreboard for the 5-stage core, complementing the EXE-stage forwarding logic. It tracks GPRs with an outstanding write from long-latency producers (loads, mul/div) whose result cannot be forwarded in time. It raises a combinational stall to ID while a source or destination of the decoding instruction is still pending. It also keeps pending/occupancy status and a stall-cycle performance counter.

## Interface
- `NUM_REGS`, 32: number of architectural GPRs; index 0 is hard-wired zero.
- `CNT_W`, 32: width of the stall-cycle counter.
- `clk` in 1: core clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `id_valid` in 1: ID holds a valid instruction this cycle.
- `id_rs1_addr` in `GPR_ADDR_SPACE`: rs1 index of the ID instruction.
- `id_rs1_re` in 1: rs1 is read.
- `id_rs2_addr` in `GPR_ADDR_SPACE`: rs2 index.
- `id_rs2_re` in 1: rs2 is read.
- `id_rd_addr` in `GPR_ADDR_SPACE`: rd index.
- `id_rd_we` in 1: instruction writes rd.
- `id_long` in 1: producer is long-latency (load/mul/div).
- `wb_done` in 1: a long-latency result is written back this cycle.
- `wb_rd_addr` in `GPR_ADDR_SPACE`: rd of that writeback.
- `flush` in 1: pipeline flush; all in-flight long ops are killed.
- `stall` out 1: ID must hold; combinational.
- `busy` out 1: at least one register pending (registered state).
- `pending_cnt` out 6: number of pending registers.
- `stall_cycles` out `CNT_W`: saturating count of cycles with `stall`=1.
- `err_sticky` out 1: set on writeback to a non-pending register.

## Operation
- State: `pending[NUM_REGS-1:0]`, `pending_cnt`, `stall_cycles`, `err_sticky`. `pending[0]` is constant 0.
- Effective pending view: `eff[i] = pending[i] & ~(wb_done & wb_rd_addr==i)`. A completing register counts as ready in its completion cycle, because the register file is write-first.
- Source hazard: `id_rsN_re & eff[id_rsN_addr]` for rs1 or rs2, with index ≠ 0.
- WAW hazard: `id_rd_we & eff[id_rd_addr]`, with rd ≠ 0.
- `stall = id_valid & ~flush & (source hazard | WAW hazard)`.
- Issue: `id_valid & ~stall & ~flush & id_rd_we & id_long & id_rd_addr!=0`. At the next edge this sets `pending[id_rd_addr]`.
- Completion: `wb_done & wb_rd_addr!=0`. At the next edge this clears `pending[wb_rd_addr]`.
  - If the bit was already 0, set `err_sticky` and leave the state otherwise unchanged.
  - `wb_rd_addr`=0 is ignored and raises no error.
- Simultaneous completion and issue to the same rd: the register ends pending. The issue wins; the WAW check uses `eff`, so no stall occurs.
- Simultaneous completion and issue to different registers: both apply. `pending_cnt` changes by net 0.
- Flush: at the next edge all `pending` bits clear and `pending_cnt` becomes 0. Same-cycle issue and completion are ignored and no error is raised. `stall_cycles` and `err_sticky` are unaffected.
- `pending_cnt` tracks `popcount(pending)` incrementally (+1 on issue, −1 on valid completion). It must always equal the popcount; this is an assertion for verification.
- `stall_cycles` increments every cycle `stall`=1 and saturates at all-ones.

## Timing
- Reset values: `pending`=0, `busy`=0, `pending_cnt`=0, `stall_cycles`=0, `err_sticky`=0.
- During reset `stall` is forced to 0.
- `stall` has zero latency: combinational from ID, WB and flush inputs plus registered `pending`.
- Issue in cycle N: the register is visible as pending from cycle N+1. A dependent instruction in ID at N+1 stalls.
- Completion in cycle N: the dependent instruction is released in cycle N, and the bit is 0 from N+1.
- `busy` and `pending_cnt` reflect registered state only; they lag `eff` by one cycle.
- Reset asserted mid-operation clears everything at that edge, overriding issue, completion and flush.

## Test plan
- Load x5 issued at cycle 1 (`id_long`=1). At cycle 2, `add x6,x5,x1` → `stall`=1. `wb_done` for x5 at cycle 4 → `stall`=0 at cycle 4, `pending_cnt` 1→0 at cycle 5, `stall_cycles`=2.
- Div writes x7 (pending). Next instruction `mul x7,...` (WAW, `id_long`) → stall until the x7 writeback cycle. In that cycle the issue occurs and x7 stays pending; `pending_cnt` stays 1.
- Long op targeting x0 → no pending bit set, `busy` stays 0, and a later read of x0 never stalls.
- x3, x4, x9 pending (`pending_cnt`=3). Assert `flush` with a concurrent issue of x10 → next cycle `pending_cnt`=0, `busy`=0, x10 not pending.
- `wb_done` with `wb_rd_addr`=12 while x12 is not pending → `err_sticky`=1 next cycle, `pending_cnt` unchanged. `err_sticky` stays set until `rst`.
- Preload `stall_cycles` to near saturation (or use `CNT_W`=4) and hold a stall for 20 cycles → counter sticks at 15.
